// File: rtl/avst_fifo_rl.sv
// Avalon-ST single-clock FIFO with configurable sink ready latency and
// show-ahead source; stores data plus sop/eop/empty sideband per beat.
module avst_fifo_rl #(
  parameter int DATABITS_PER_SYMBOL = 8,
  parameter int SYMBOLS_PER_BEAT    = 4,
  parameter int ADDR_WIDTH          = 3,
  parameter int READY_LATENCY       = 0,
  parameter int AF_THRESHOLD        = (1 << ADDR_WIDTH) - 2,
  localparam int DATA_WIDTH         = SYMBOLS_PER_BEAT * DATABITS_PER_SYMBOL,
  localparam int EW                 = (SYMBOLS_PER_BEAT > 1) ? $clog2(SYMBOLS_PER_BEAT) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  input  logic                  in_sop,
  input  logic                  in_eop,
  input  logic [EW-1:0]         in_empty,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  output logic                  out_sop,
  output logic                  out_eop,
  output logic [EW-1:0]         out_empty,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH:0]   fill_level,
  output logic                  almost_full,
  output logic                  overflow,
  input  logic                  clr_overflow
);

  localparam int DEPTH   = 1 << ADDR_WIDTH;
  localparam int PW      = ADDR_WIDTH + 1;
  localparam int ENTRY_W = DATA_WIDTH + 2 + EW;
  // One slot beyond the in-flight beats is held back, so a compliant source never fills the store.
  localparam int signed RDY_LIMIT = DEPTH - 2 - READY_LATENCY;

  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]      r_wr_ptr;
  logic [PW-1:0]      r_rd_ptr;
  logic [PW-1:0]      r_fill;
  logic               r_in_ready;
  logic               r_af;
  logic               r_ovf;

  logic               w_empty;
  logic               w_full;
  logic               w_qual_rdy;
  logic               w_push;
  logic               w_drop;
  logic               w_pop;
  logic [PW-1:0]      w_wr_nxt;
  logic [PW-1:0]      w_rd_nxt;
  logic [PW-1:0]      w_fill_nxt;
  logic               w_rdy_nxt;
  logic               w_af_nxt;
  logic [ENTRY_W-1:0] w_rd_entry;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[ADDR_WIDTH-1:0] == r_rd_ptr[ADDR_WIDTH-1:0]) &&
                   (r_wr_ptr[ADDR_WIDTH] != r_rd_ptr[ADDR_WIDTH]);

  // A sink beat is qualified by the ready value seen READY_LATENCY cycles earlier.
  generate
    if (READY_LATENCY == 0) begin : g_no_hist
      assign w_qual_rdy = r_in_ready;
    end else if (READY_LATENCY == 1) begin : g_hist1
      logic r_rdy_hist;
      always_ff @(posedge clk) begin
        if (!rst_n) r_rdy_hist <= 1'b0;
        else        r_rdy_hist <= r_in_ready;
      end
      assign w_qual_rdy = r_rdy_hist;
    end else begin : g_histn
      logic [READY_LATENCY-1:0] r_rdy_hist;
      always_ff @(posedge clk) begin
        if (!rst_n) r_rdy_hist <= '0;
        else        r_rdy_hist <= {r_rdy_hist[READY_LATENCY-2:0], r_in_ready};
      end
      assign w_qual_rdy = r_rdy_hist[READY_LATENCY-1];
    end
  endgenerate

  assign w_push     = in_valid && w_qual_rdy && !w_full;
  assign w_drop     = in_valid && !w_push;
  assign w_pop      = !w_empty && out_ready;
  assign w_wr_nxt   = r_wr_ptr + PW'(w_push);
  assign w_rd_nxt   = r_rd_ptr + PW'(w_pop);
  assign w_fill_nxt = w_wr_nxt - w_rd_nxt;
  assign w_rdy_nxt  = (int'(w_fill_nxt) <= RDY_LIMIT);
  assign w_af_nxt   = (int'(w_fill_nxt) >= AF_THRESHOLD);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fill     <= '0;
      r_in_ready <= 1'b0;
      r_af       <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_wr_ptr   <= w_wr_nxt;
      r_rd_ptr   <= w_rd_nxt;
      r_fill     <= w_fill_nxt;
      r_in_ready <= w_rdy_nxt;
      r_af       <= w_af_nxt;
      if (w_drop)            r_ovf <= 1'b1;
      else if (clr_overflow) r_ovf <= 1'b0;
    end
  end

  // Storage is data-path only and is never reset.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= {in_sop, in_eop, in_empty, in_data};
  end

  assign w_rd_entry  = r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];
  assign out_data    = w_rd_entry[DATA_WIDTH-1:0];
  assign out_empty   = w_rd_entry[DATA_WIDTH +: EW];
  assign out_eop     = w_rd_entry[DATA_WIDTH+EW];
  assign out_sop     = w_rd_entry[DATA_WIDTH+EW+1];
  assign out_valid   = !w_empty;
  assign in_ready    = r_in_ready;
  assign fill_level  = r_fill;
  assign almost_full = r_af;
  assign overflow    = r_ovf;

endmodule

// File: tb/tb_avst_fifo_rl.sv
// Scoreboard bench for avst_fifo_rl: three instances (RL=0/depth 8, RL=2/depth 8,
// RL=0/depth 4) exercised one at a time against a cycle-level reference model.
module tb_avst_fifo_rl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0, in_sop = 1'b0, in_eop = 1'b0;
  logic [1:0]  in_empty = '0;
  logic        out_ready = 1'b0, clr_ovf = 1'b0;
  int          sel = 0;

  logic vld0, vld1, vld2, ord0, ord1, ord2;
  assign vld0 = in_valid && (sel == 0);
  assign vld1 = in_valid && (sel == 1);
  assign vld2 = in_valid && (sel == 2);
  assign ord0 = out_ready && (sel == 0);
  assign ord1 = out_ready && (sel == 1);
  assign ord2 = out_ready && (sel == 2);

  logic [31:0] o_data [3];
  logic        o_valid[3], o_sop[3], o_eop[3], o_rdy[3], o_af[3], o_ovf[3];
  logic [1:0]  o_empty[3];
  logic [3:0]  fill0, fill1;
  logic [2:0]  fill2;

  avst_fifo_rl #(.ADDR_WIDTH(3), .READY_LATENCY(0)) u_rl0 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(vld0), .in_sop(in_sop),
    .in_eop(in_eop), .in_empty(in_empty), .in_ready(o_rdy[0]), .out_data(o_data[0]),
    .out_valid(o_valid[0]), .out_sop(o_sop[0]), .out_eop(o_eop[0]), .out_empty(o_empty[0]),
    .out_ready(ord0), .fill_level(fill0), .almost_full(o_af[0]), .overflow(o_ovf[0]),
    .clr_overflow(clr_ovf));

  avst_fifo_rl #(.ADDR_WIDTH(3), .READY_LATENCY(2)) u_rl2 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(vld1), .in_sop(in_sop),
    .in_eop(in_eop), .in_empty(in_empty), .in_ready(o_rdy[1]), .out_data(o_data[1]),
    .out_valid(o_valid[1]), .out_sop(o_sop[1]), .out_eop(o_eop[1]), .out_empty(o_empty[1]),
    .out_ready(ord1), .fill_level(fill1), .almost_full(o_af[1]), .overflow(o_ovf[1]),
    .clr_overflow(clr_ovf));

  avst_fifo_rl #(.ADDR_WIDTH(2), .READY_LATENCY(0)) u_aw2 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(vld2), .in_sop(in_sop),
    .in_eop(in_eop), .in_empty(in_empty), .in_ready(o_rdy[2]), .out_data(o_data[2]),
    .out_valid(o_valid[2]), .out_sop(o_sop[2]), .out_eop(o_eop[2]), .out_empty(o_empty[2]),
    .out_ready(ord2), .fill_level(fill2), .almost_full(o_af[2]), .overflow(o_ovf[2]),
    .clr_overflow(clr_ovf));

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic int obs_fill();
    case (sel)
      0:       return int'(fill0);
      1:       return int'(fill1);
      default: return int'(fill2);
    endcase
  endfunction

  function automatic int rl_of(input int s);
    return (s == 1) ? 2 : 0;
  endfunction

  function automatic int depth_of(input int s);
    return (s == 2) ? 4 : 8;
  endfunction

  // Reference model state
  int          mfill = 0;
  bit          movf = 1'b0;
  bit          hist[3][4];
  logic [35:0] q[$];

  // Wrap-bit toggle monitor for the depth-4 instance
  bit mon_en = 1'b0;
  int wr_tog = 0, rd_tog = 0;
  logic wr_prev = 1'b0, rd_prev = 1'b0;
  always @(negedge clk) begin
    if (mon_en) begin
      if (u_aw2.r_wr_ptr[2] !== wr_prev) wr_tog++;
      if (u_aw2.r_rd_ptr[2] !== rd_prev) rd_tog++;
      wr_prev = u_aw2.r_wr_ptr[2];
      rd_prev = u_aw2.r_rd_ptr[2];
    end
  end

  task automatic clear_model();
    mfill = 0;
    movf  = 1'b0;
    q.delete();
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 4; i++) hist[k][i] = 1'b0;
  endtask

  // Called 1 time unit after a rising edge; drives one cycle and checks the result.
  task automatic cycle(input bit v, input logic [31:0] d, input bit sop, input bit eop,
                       input logic [1:0] emp, input bit ordy, input bit clr);
    bit qual, pop, acc, full;
    bit rprev[3];
    logic [35:0] e;
    int rl, dep;
    rl   = rl_of(sel);
    dep  = depth_of(sel);
    qual = (rl == 0) ? o_rdy[sel] : hist[sel][rl-1];
    full = (mfill == dep);
    pop  = o_valid[sel] && ordy;
    if (pop) begin
      if (q.size() == 0) chk_eq("pop_without_data", 1, 0);
      else begin
        e = q.pop_front();
        chk_eq("out_data", o_data[sel], e[31:0]);
        chk_eq("out_sop", o_sop[sel], e[35]);
        chk_eq("out_eop", o_eop[sel], e[34]);
        chk_eq("out_empty", o_empty[sel], e[33:32]);
      end
    end
    acc = v && qual && !full;
    for (int k = 0; k < 3; k++) rprev[k] = o_rdy[k];
    in_valid = v; in_data = d; in_sop = sop; in_eop = eop; in_empty = emp;
    out_ready = ordy; clr_ovf = clr;
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_empty = '0;
    out_ready = 1'b0; clr_ovf = 1'b0;
    if (acc) begin
      q.push_back({sop, eop, emp, d});
      mfill++;
    end
    if (pop) mfill--;
    if (v && !acc) movf = 1'b1;
    else if (clr)  movf = 1'b0;
    for (int k = 0; k < 3; k++) begin
      for (int i = 3; i > 0; i--) hist[k][i] = hist[k][i-1];
      hist[k][0] = rprev[k];
    end
    chk_eq("fill_level", obs_fill(), mfill);
    chk_eq("out_valid", o_valid[sel], mfill != 0);
    chk_eq("in_ready", o_rdy[sel], (mfill + rl) <= (dep - 2));
    chk_eq("almost_full", o_af[sel], mfill >= (dep - 2));
    chk_eq("overflow", o_ovf[sel], movf);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk_eq("rst_fill", obs_fill(), 0);
    chk_eq("rst_out_valid", o_valid[sel], 0);
    chk_eq("rst_in_ready", o_rdy[sel], 0);
    chk_eq("rst_overflow", o_ovf[sel], 0);
    rst_n = 1'b1;
    clear_model();
    @(posedge clk);
    #1;
    chk_eq("release_in_ready", o_rdy[sel], 1);
    chk_eq("release_fill", obs_fill(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    bit v;
    clear_model();
    sel = 0;
    do_reset();

    // RL=0, depth 8: source pushes only when ready; the 8th beat never gets a ready.
    idx = 0;
    for (int c = 0; c < 20; c++) begin
      v = (idx < 8) && o_rdy[0];
      cycle(v, 32'h11 * (idx + 1), 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
      if (v) idx++;
    end
    chk_eq("rl0_fill_stall", obs_fill(), 7);
    chk_eq("rl0_accepted", idx, 7);
    chk_eq("rl0_ready_low", o_rdy[0], 0);
    chk_eq("rl0_no_overflow", o_ovf[0], 0);
    for (int c = 0; c < 10; c++) cycle(1'b0, '0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
    chk_eq("rl0_drained_valid", o_valid[0], 0);
    chk_eq("rl0_drained_queue", q.size(), 0);

    // Three-beat packet with random out_ready
    idx = 0;
    for (int c = 0; c < 20 && idx < 3; c++) begin
      v = o_rdy[0];
      cycle(v, 32'hDEAD_0000 + idx, idx == 0, idx == 2, (idx == 2) ? 2'd2 : 2'd0,
            1'($urandom_range(0, 1)), 1'b0);
      if (v) idx++;
    end
    for (int c = 0; c < 40 && q.size() > 0; c++)
      cycle(1'b0, '0, 1'b0, 1'b0, 2'd0, 1'($urandom_range(0, 1)), 1'b0);
    for (int c = 0; c < 5; c++) cycle(1'b0, '0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
    chk_eq("pkt_beats_sent", idx, 3);
    chk_eq("pkt_drained", q.size(), 0);

    // RL=2: source answers each ready exactly two cycles later.
    sel = 1;
    idx = 0;
    for (int c = 0; c < 16; c++) begin
      v = hist[1][1];
      cycle(v, 32'h100 + idx, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
      if (v) idx++;
      if (obs_fill() == 4) chk_eq("rl2_ready_at4", o_rdy[1], 1);
      if (obs_fill() == 5) chk_eq("rl2_ready_at5", o_rdy[1], 0);
    end
    chk_eq("rl2_fill_le7", obs_fill() <= 7, 1);
    chk_eq("rl2_fill", obs_fill(), 7);
    chk_eq("rl2_no_overflow", o_ovf[1], 0);

    // Unqualified beat, clear, and set-beats-clear
    cycle(1'b1, 32'hBAD0_0001, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    chk_eq("unq_fill", obs_fill(), 7);
    chk_eq("unq_overflow_set", o_ovf[1], 1);
    cycle(1'b0, '0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
    chk_eq("unq_overflow_clr", o_ovf[1], 0);
    cycle(1'b1, 32'hBAD0_0002, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
    chk_eq("set_wins_clr", o_ovf[1], 1);
    cycle(1'b0, '0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
    for (int c = 0; c < 12; c++) cycle(1'b0, '0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
    chk_eq("rl2_drained_queue", q.size(), 0);

    // Depth 4 full-rate streaming, 100 beats
    sel = 2;
    wr_tog = 0; rd_tog = 0;
    wr_prev = u_aw2.r_wr_ptr[2];
    rd_prev = u_aw2.r_rd_ptr[2];
    mon_en = 1'b1;
    for (int i = 0; i < 100; i++) begin
      cycle(1'b1, 32'h5A00_0000 + 32'(i * 3), 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
      chk_eq("stream_fill", obs_fill(), 1);
    end
    for (int c = 0; c < 6; c++) cycle(1'b0, '0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
    @(negedge clk);
    mon_en = 1'b0;
    #2;
    chk_eq("stream_drained", q.size(), 0);
    chk_eq("wr_wrap_toggles", wr_tog, 25);
    chk_eq("rd_wrap_toggles", rd_tog, 25);
    @(posedge clk);
    #1;

    // Reset with five beats stored
    sel = 0;
    for (int b = 0; b < 5; b++) cycle(1'b1, 32'h500 + b, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    chk_eq("pre_reset_fill", obs_fill(), 5);
    do_reset();
    cycle(1'b1, 32'hCAFE_F00D, 1'b1, 1'b1, 2'd1, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
    chk_eq("post_reset_queue", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
